// File: rtl/read_iq_if.sv
// Byte-FIFO input and I/Q sample-FIFO output signals of the IQ assembler.
// The master side is the assembler; the slave side is the surrounding FIFO fabric.
interface read_iq_if;
  logic [7:0]  in_dout;
  logic        in_empty;
  logic        in_rd_en;
  logic [31:0] i_out;
  logic [31:0] q_out;
  logic        i_wr_en;
  logic        q_wr_en;
  logic        i_full;
  logic        q_full;

  modport master (
    input  in_dout, in_empty, i_full, q_full,
    output in_rd_en, i_out, q_out, i_wr_en, q_wr_en
  );

  modport slave (
    output in_dout, in_empty, i_full, q_full,
    input  in_rd_en, i_out, q_out, i_wr_en, q_wr_en
  );
endinterface

// File: rtl/read_iq.sv
// Assembles little-endian 16-bit I/Q pairs from a byte FIFO, sign-extends and shifts by BITS.
// Pair written the cycle after its 4th pop; a full I or Q FIFO stalls both writes and all pops.
module read_iq #(
  parameter int BITS             = 10,
  parameter int BYTES_PER_SAMPLE = 4
) (
  input logic       clock,
  input logic       reset,
  read_iq_if.master bus
);

  typedef enum logic [0:0] {S_READ = 1'b0, S_WRITE = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [15:0] i_asm_q, i_asm_d;
  logic [15:0] q_asm_q, q_asm_d;
  logic [31:0] i_out_q, i_out_d;
  logic [31:0] q_out_q, q_out_d;
  logic        pop;
  logic        push;

  function automatic logic [31:0] quant(input logic [15:0] s);
    logic [31:0] w;
    w = {{16{s[15]}}, s};
    return w << BITS;
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_READ;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_READ:  if (!bus.in_empty && cnt_q == 2'd3) state_d = S_WRITE;
      S_WRITE: if (!bus.i_full && !bus.q_full)     state_d = S_READ;
    endcase
  end

  // Strobes are gated by reset so nothing pops or pushes while it is held.
  always_comb begin
    pop  = 1'b0;
    push = 1'b0;
    if (reset) begin
      case (state_q)
        S_READ:  pop  = !bus.in_empty;
        S_WRITE: push = !bus.i_full && !bus.q_full;
      endcase
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    i_asm_d = i_asm_q;
    q_asm_d = q_asm_q;
    i_out_d = i_out_q;
    q_out_d = q_out_q;
    if (pop) begin
      cnt_d = cnt_q + 2'd1;
      case (cnt_q)
        2'd0: i_asm_d[7:0]  = bus.in_dout;
        2'd1: i_asm_d[15:8] = bus.in_dout;
        2'd2: q_asm_d[7:0]  = bus.in_dout;
        default: begin
          q_asm_d[15:8] = bus.in_dout;
          i_out_d       = quant(i_asm_d);
          q_out_d       = quant(q_asm_d);
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q   <= 2'd0;
      i_asm_q <= 16'd0;
      q_asm_q <= 16'd0;
      i_out_q <= 32'd0;
      q_out_q <= 32'd0;
    end else begin
      cnt_q   <= cnt_d;
      i_asm_q <= i_asm_d;
      q_asm_q <= q_asm_d;
      i_out_q <= i_out_d;
      q_out_q <= q_out_d;
    end
  end

  assign bus.in_rd_en = pop;
  assign bus.i_wr_en  = push;
  assign bus.q_wr_en  = push;
  assign bus.i_out    = i_out_q;
  assign bus.q_out    = q_out_q;

  a_pair_width: assert property (@(posedge clock) BYTES_PER_SAMPLE == 4);
  a_paired_wr:  assert property (@(posedge clock) disable iff (!reset)
                                 bus.i_wr_en == bus.q_wr_en);

endmodule

// File: tb/tb_read_iq.sv
// Directed bench for read_iq: vector table, backpressure, bursty input, mid-sample reset, throughput.
module tb_read_iq;
  localparam int BITS = 10;

  typedef struct {
    logic [7:0]  b0, b1, b2, b3;
    logic [31:0] ei, eq;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  read_iq_if bus();

  read_iq #(.BITS(BITS), .BYTES_PER_SAMPLE(4)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int pops = 0;
  int writes = 0;
  int cyc = 0;
  int gap_pct = 0;
  logic rd_seen = 1'b0;
  logic [7:0]  byteq[$];
  logic [31:0] obs_i[$], obs_q[$];
  int          obs_cyc[$], obs_pops[$];
  logic [31:0] exp_i[$], exp_q[$];
  vec_t        vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [7:0] lo, input logic [7:0] hi);
    int v;
    v = int'($signed({hi, lo}));
    return 32'(v * (1 << BITS));
  endfunction

  always @(posedge clock) cyc <= cyc + 1;

  // Mid-cycle monitor: strobes seen here take effect on the next rising edge.
  always @(negedge clock) begin
    rd_seen = bus.in_rd_en;
    if (bus.in_rd_en) pops++;
    if (bus.i_wr_en || bus.q_wr_en) begin
      check("wr_pair", {31'd0, bus.i_wr_en}, {31'd0, bus.q_wr_en});
      writes++;
      obs_i.push_back(bus.i_out);
      obs_q.push_back(bus.q_out);
      obs_cyc.push_back(cyc);
      obs_pops.push_back(pops);
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
    if (rd_seen && byteq.size() > 0) void'(byteq.pop_front());
    if (byteq.size() > 0 && $urandom_range(99) >= gap_pct) begin
      bus.in_empty = 1'b0;
      bus.in_dout  = byteq[0];
    end else begin
      bus.in_empty = 1'b1;
      bus.in_dout  = 8'hA5;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic run_until_writes(input int w0, input int n, input int budget);
    int k = 0;
    while (writes - w0 < n && k < budget) begin
      tick();
      k++;
    end
  endtask

  task automatic push4(input logic [7:0] b0, b1, b2, b3);
    byteq.push_back(b0);
    byteq.push_back(b1);
    byteq.push_back(b2);
    byteq.push_back(b3);
  endtask

  task automatic clear_obs();
    obs_i.delete(); obs_q.delete(); obs_cyc.delete(); obs_pops.delete();
    exp_i.delete(); exp_q.delete();
  endtask

  task automatic stall_cycle(input string tag);
    @(negedge clock);
    #1;
    check({tag, "_wr"}, {30'd0, bus.i_wr_en, bus.q_wr_en}, 32'd0);
    check({tag, "_rd"}, {31'd0, bus.in_rd_en}, 32'd0);
    check({tag, "_hold_i"}, bus.i_out, 32'h0048D000);
    tick();
  endtask

  initial begin
    int w0, p0, k;
    logic [7:0] r0, r1, r2, r3;

    vecs[0] = '{8'h34, 8'h12, 8'hCD, 8'hAB, 32'h0048D000, 32'hFEAF3400};
    vecs[1] = '{8'hFF, 8'h7F, 8'h00, 8'h80, 32'h01FFFC00, 32'hFE000000};
    vecs[2] = '{8'h00, 8'h00, 8'hFF, 8'hFF, 32'h00000000, 32'hFFFFFC00};
    vecs[3] = '{8'h01, 8'h00, 8'h02, 8'h00, 32'h00000400, 32'h00000800};
    vecs[4] = '{8'h00, 8'h80, 8'hFF, 8'h7F, 32'hFE000000, 32'h01FFFC00};
    vecs[5] = '{8'hAA, 8'h55, 8'h55, 8'hAA, 32'h0156A800, 32'hFEA95400};

    bus.in_dout  = 8'h5A;
    bus.in_empty = 1'b0;
    bus.i_full   = 1'b0;
    bus.q_full   = 1'b0;

    // Reset state, with a byte on offer so a leaky rd_en would show.
    repeat (3) @(negedge clock);
    #1;
    check("rst_rd_en", {31'd0, bus.in_rd_en}, 32'd0);
    check("rst_wr_en", {30'd0, bus.i_wr_en, bus.q_wr_en}, 32'd0);
    check("rst_i_out", bus.i_out, 32'd0);
    check("rst_q_out", bus.q_out, 32'd0);
    @(posedge clock);
    #2;
    bus.in_empty = 1'b1;
    reset = 1'b1;
    idle(2);

    for (int v = 0; v < 6; v++) begin
      clear_obs();
      w0 = writes;
      p0 = pops;
      push4(vecs[v].b0, vecs[v].b1, vecs[v].b2, vecs[v].b3);
      run_until_writes(w0, 1, 40);
      idle(6);
      check($sformatf("vec%0d_writes", v), writes - w0, 32'd1);
      check($sformatf("vec%0d_pops", v), pops - p0, 32'd4);
      check($sformatf("vec%0d_i", v), obs_i.size() > 0 ? obs_i[0] : 32'hxxxxxxxx, vecs[v].ei);
      check($sformatf("vec%0d_q", v), obs_q.size() > 0 ? obs_q[0] : 32'hxxxxxxxx, vecs[v].eq);
    end

    // Backpressure: I full for 6 write cycles, then Q full alone for 3.
    clear_obs();
    w0 = writes;
    p0 = pops;
    bus.i_full = 1'b1;
    push4(8'h34, 8'h12, 8'hCD, 8'hAB);
    push4(8'h01, 8'h00, 8'h02, 8'h00);
    k = 0;
    while (pops - p0 < 4 && k < 40) begin
      tick();
      k++;
    end
    check("bp_pops", pops - p0, 32'd4);
    repeat (6) stall_cycle("bp_ifull");
    bus.i_full = 1'b0;
    bus.q_full = 1'b1;
    repeat (3) stall_cycle("bp_qfull");
    bus.q_full = 1'b0;
    run_until_writes(w0, 2, 40);
    idle(6);
    check("bp_writes", writes - w0, 32'd2);
    check("bp_first_i", obs_i.size() > 0 ? obs_i[0] : 32'hxxxxxxxx, 32'h0048D000);
    check("bp_first_q", obs_q.size() > 0 ? obs_q[0] : 32'hxxxxxxxx, 32'hFEAF3400);
    check("bp_second_i", obs_i.size() > 1 ? obs_i[1] : 32'hxxxxxxxx, 32'h00000400);
    check("bp_gap", obs_cyc.size() > 1 ? obs_cyc[1] - obs_cyc[0] : -1, 32'd5);

    // Bursty input against the reference model.
    clear_obs();
    w0 = writes;
    p0 = pops;
    gap_pct = 40;
    for (int s = 0; s < 100; s++) begin
      r0 = 8'($urandom); r1 = 8'($urandom); r2 = 8'($urandom); r3 = 8'($urandom);
      push4(r0, r1, r2, r3);
      exp_i.push_back(model(r0, r1));
      exp_q.push_back(model(r2, r3));
    end
    run_until_writes(w0, 100, 5000);
    idle(8);
    gap_pct = 0;
    check("burst_writes", writes - w0, 32'd100);
    check("burst_pops", pops - p0, 32'd400);
    for (int s = 0; s < 100; s++) begin
      check($sformatf("burst%0d_i", s), s < obs_i.size() ? obs_i[s] : 32'hxxxxxxxx, exp_i[s]);
      check($sformatf("burst%0d_q", s), s < obs_q.size() ? obs_q[s] : 32'hxxxxxxxx, exp_q[s]);
    end

    // Reset in the middle of a sample.
    clear_obs();
    p0 = pops;
    push4(8'h11, 8'h22, 8'h33, 8'h44);
    k = 0;
    while (pops - p0 < 2 && k < 40) begin
      tick();
      k++;
    end
    check("mid_pops_before", pops - p0, 32'd2);
    reset = 1'b0;
    byteq.delete();
    idle(2);
    @(negedge clock);
    #1;
    check("mid_rst_i_out", bus.i_out, 32'd0);
    check("mid_rst_rd_en", {31'd0, bus.in_rd_en}, 32'd0);
    @(posedge clock);
    #2;
    reset = 1'b1;
    w0 = writes;
    push4(8'h01, 8'h00, 8'h02, 8'h00);
    run_until_writes(w0, 1, 40);
    idle(6);
    check("mid_writes", writes - w0, 32'd1);
    check("mid_i", obs_i.size() > 0 ? obs_i[0] : 32'hxxxxxxxx, 32'h00000400);
    check("mid_q", obs_q.size() > 0 ? obs_q[0] : 32'hxxxxxxxx, 32'h00000800);

    // Throughput with the input never empty and outputs never full.
    clear_obs();
    w0 = writes;
    for (int s = 0; s < 50; s++) begin
      r0 = 8'($urandom); r1 = 8'($urandom); r2 = 8'($urandom); r3 = 8'($urandom);
      push4(r0, r1, r2, r3);
      exp_i.push_back(model(r0, r1));
      exp_q.push_back(model(r2, r3));
    end
    run_until_writes(w0, 50, 400);
    idle(6);
    check("tp_writes", writes - w0, 32'd50);
    for (int s = 1; s < 50; s++) begin
      check($sformatf("tp_period%0d", s),
            s < obs_cyc.size() ? obs_cyc[s] - obs_cyc[s-1] : -1, 32'd5);
    end
    check("tp_pops", obs_pops.size() == 50 ? obs_pops[49] - obs_pops[0] : -1, 32'd196);
    for (int s = 0; s < 50; s++) begin
      check($sformatf("tp%0d_i", s), s < obs_i.size() ? obs_i[s] : 32'hxxxxxxxx, exp_i[s]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/read_iq.md
Name: read_iq

Overview:
- Front-end stage of the FM receive chain; sits directly upstream of the complex channel FIR.
- Pops raw interleaved IQ bytes from the input byte FIFO and assembles 16-bit signed little-endian I and Q samples.
- Sign-extends each sample to 32 bits, quantizes it (arithmetic left shift by BITS) and pushes it into the separate I and Q sample FIFOs that feed the FIR.

Parameters:
- BITS, 10: quantization shift; output = sign_extend32(sample16) <<< BITS, truncated to 32 bits.
- BYTES_PER_SAMPLE, 4: bytes per IQ pair; fixed at 4, present for documentation and assertions only.

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_dout  in  8  head byte of input FIFO (show-ahead: valid whenever in_empty=0).
- in_empty  in  1  input FIFO empty.
- in_rd_en  out  1  pop input FIFO this cycle.
- i_out  out  32  quantized I sample.
- q_out  out  32  quantized Q sample.
- i_wr_en  out  1  push i_out into I FIFO.
- q_wr_en  out  1  push q_out into Q FIFO.
- i_full  in  1  I FIFO full.
- q_full  in  1  Q FIFO full.

Behaviour:
- Reset (reset=0, asynchronous):
  - State=S_READ, byte counter=0, I/Q assembly registers=0.
  - i_out=q_out=0; in_rd_en=i_wr_en=q_wr_en=0 while reset is asserted.
- Byte order per sample: byte0=I[7:0], byte1=I[15:8], byte2=Q[7:0], byte3=Q[15:8].
- S_READ:
  - in_rd_en = !in_empty (combinational).
  - On each pop, in_dout is captured into the slot selected by the byte counter (0..3) and the counter increments.
  - When the counter is 3 and a pop occurs: counter wraps to 0 and next state is S_WRITE.
  - The registered i_out/q_out are loaded on that same edge from the final assembled values, including the byte just popped.
  - in_empty=1: no pop, state and counter hold; gaps of any length are allowed between any two bytes.
- S_WRITE:
  - in_rd_en=0.
  - i_wr_en = q_wr_en = !i_full && !q_full. Both are asserted together or not at all; a sample is never written to only one FIFO.
  - When both are asserted, next state is S_READ.
  - Otherwise the state holds, with i_out/q_out stable and wr_en low.
- Arithmetic:
  - I16/Q16 are treated as signed two's complement.
  - Output = {{16{s[15]}}, s} shifted left by BITS, low 32 bits kept. No saturation; with BITS=10 no overflow is possible.
- Throughput: an unstalled stream yields one IQ pair every 5 cycles (4 pops + 1 write).
- Latency: the write cycle is the cycle immediately after the 4th pop edge.
- i_out/q_out only change on a 4th-byte pop edge and hold otherwise.
- Reset mid-sample discards partially assembled bytes; the first byte popped after reset release is byte0.

Test Plan:
- Single sample: bytes 0x34,0x12,0xCD,0xAB -> exactly one write with i_out=0x0048D000, q_out=0xFEAF3400.
- Extremes: bytes 0xFF,0x7F,0x00,0x80 -> i_out=0x01FFFC00, q_out=0xFE000000. Then 0x00,0x00,0xFF,0xFF -> i_out=0x00000000, q_out=0xFFFFFC00.
- Backpressure: hold i_full=1 for 6 cycles of S_WRITE, then q_full=1 alone for 3 cycles.
  - No wr_en and no in_rd_en during either stall.
  - Exactly one simultaneous i_wr_en/q_wr_en after both are clear, with values unchanged.
- Bursty input: randomly deassert and assert in_empty between bytes of 100 random samples.
  - Output sequence matches the reference model bit-exact.
  - Counts of in_rd_en pops and of writes are exactly 400 and 100.
- Reset mid-sample: pop 0x11,0x22, assert reset, release, then pop 0x01,0x00,0x02,0x00 -> single write i_out=0x00000400, q_out=0x00000800.
- Throughput: FIFO never empty and never full for 50 samples -> wr_en pulses exactly every 5 cycles, in_rd_en duty 4/5.
